bsg_upstream_credit_sched: RTL and testbench

Credit-based beat scheduler for the upstream off-chip output path, in the io clock domain. Accepts 64-bit core words over a valid/ready handshake and splits each into two 32-bit beats, driving 16 bits to each of the two output channels (ch0, ch1) in lockstep. A beat is issued only when both channels hold a credit. Credits are replenished by per-channel token toggles returned from the receiver, already synchronized into this domain.

---
 rtl/bsg_upstream_credit_sched.sv | 133 +++++++++++++
 tb/tb_bsg_upstream_credit_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_upstream_credit_sched.sv
// Credit-gated beat scheduler: splits 64-bit core words into two 32-bit beats
// carried 16 bits per channel on ch0/ch1, issued only while both channels hold credit.
module bsg_upstream_credit_sched #(
  parameter int CREDITS     = 16,
  parameter int TOKEN_BATCH = 4,
  parameter int CW          = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_valid_i,
  input  logic [63:0]   core_data_i,
  output logic          core_ready_o,
  input  logic [1:0]    token_i,
  input  logic [1:0]    ch_ready_i,
  output logic          ch_valid_o,
  output logic [15:0]   ch0_data_o,
  output logic [15:0]   ch1_data_o,
  output logic [CW-1:0] credit0_o,
  output logic [CW-1:0] credit1_o,
  output logic [6:0]    sent_cnt_o,
  output logic          err_o
);

  // Sum width covers a full pool plus one token batch before saturation.
  localparam int SW = $clog2(CREDITS + TOKEN_BATCH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [63:0]   r_hold;
  logic [1:0]    r_token_q;
  logic [CW-1:0] r_credit0;
  logic [CW-1:0] r_credit1;
  logic [6:0]    r_sent_cnt;
  logic          r_err;

  logic          w_busy;
  logic          w_valid;
  logic          w_fire;
  logic          w_load;
  logic [1:0]    w_edge;
  logic [SW-1:0] w_sum0;
  logic [SW-1:0] w_sum1;
  logic [CW-1:0] w_credit0_nxt;
  logic [CW-1:0] w_credit1_nxt;
  logic          w_ovf0;
  logic          w_ovf1;

  assign w_busy  = (r_state == BEAT0) || (r_state == BEAT1);
  // Gating on nonzero credit is what rules out underflow in the counters below.
  assign w_valid = w_busy && (r_credit0 != '0) && (r_credit1 != '0);
  assign w_fire  = w_valid && ch_ready_i[0] && ch_ready_i[1];
  assign w_edge  = token_i ^ r_token_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    core_ready_o = 1'b0;
    ch0_data_o   = 16'h0000;
    ch1_data_o   = 16'h0000;
    unique case (r_state)
      IDLE: begin
        core_ready_o = 1'b1;
        if (core_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = BEAT0;
        end
      end
      BEAT0: begin
        ch0_data_o = r_hold[15:0];
        ch1_data_o = r_hold[31:16];
        if (w_fire) w_state_nxt = BEAT1;
      end
      BEAT1: begin
        ch0_data_o = r_hold[47:32];
        ch1_data_o = r_hold[63:48];
        if (w_fire) begin
          core_ready_o = 1'b1;
          if (core_valid_i) begin
            w_load      = 1'b1;
            w_state_nxt = BEAT0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sum0 = SW'(r_credit0) + (w_edge[0] ? SW'(TOKEN_BATCH) : '0) - SW'(w_fire);
    w_sum1 = SW'(r_credit1) + (w_edge[1] ? SW'(TOKEN_BATCH) : '0) - SW'(w_fire);
    w_ovf0 = (w_sum0 > SW'(CREDITS));
    w_ovf1 = (w_sum1 > SW'(CREDITS));
    w_credit0_nxt = w_ovf0 ? CW'(CREDITS) : w_sum0[CW-1:0];
    w_credit1_nxt = w_ovf1 ? CW'(CREDITS) : w_sum1[CW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_token_q  <= '0;
      r_credit0  <= CW'(CREDITS);
      r_credit1  <= CW'(CREDITS);
      r_sent_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_token_q <= token_i;
      r_credit0 <= w_credit0_nxt;
      r_credit1 <= w_credit1_nxt;
      if (w_load) r_hold <= core_data_i;
      if (w_fire) r_sent_cnt <= r_sent_cnt + 7'd1;
      if (w_ovf0 || w_ovf1) r_err <= 1'b1;
    end
  end

  assign ch_valid_o = w_valid;
  assign credit0_o  = r_credit0;
  assign credit1_o  = r_credit1;
  assign sent_cnt_o = r_sent_cnt;
  assign err_o      = r_err;

endmodule

// File: tb/tb_bsg_upstream_credit_sched.sv
// Directed bench for bsg_upstream_credit_sched: accepted words push expected beats
// into a scoreboard that a negedge monitor drains on every fire.
module tb_bsg_upstream_credit_sched;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_valid_i;
  logic [63:0]   core_data_i;
  logic          core_ready_o;
  logic [1:0]    token_i;
  logic [1:0]    ch_ready_i;
  logic          ch_valid_o;
  logic [15:0]   ch0_data_o;
  logic [15:0]   ch1_data_o;
  logic [CW-1:0] credit0_o;
  logic [CW-1:0] credit1_o;
  logic [6:0]    sent_cnt_o;
  logic          err_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q[$];

  bsg_upstream_credit_sched #(.CREDITS(16), .TOKEN_BATCH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_valid_i (core_valid_i),
    .core_data_i  (core_data_i),
    .core_ready_o (core_ready_o),
    .token_i      (token_i),
    .ch_ready_i   (ch_ready_i),
    .ch_valid_o   (ch_valid_o),
    .ch0_data_o   (ch0_data_o),
    .ch1_data_o   (ch1_data_o),
    .credit0_o    (credit0_o),
    .credit1_o    (credit1_o),
    .sent_cnt_o   (sent_cnt_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Fires happen on the posedge after this sample point; inputs change at posedge+1.
  always @(negedge clk) begin
    if (!rst && ch_valid_o && ch_ready_i[0] && ch_ready_i[1]) begin
      if (sb_q.size() == 0) check("beat_expected_present", 64'(sb_q.size()), 64'd1);
      else check("beat_data", {ch1_data_o, ch0_data_o}, sb_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    core_valid_i = 1'b0;
    core_data_i  = '0;
    token_i      = 2'b00;
    ch_ready_i   = 2'b11;
    rst          = 1'b1;
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
  endtask

  // Leaves core_valid_i high so the caller can chain words without a bubble.
  task automatic send_word(input logic [63:0] d, output int waits);
    logic acc;
    core_valid_i = 1'b1;
    core_data_i  = d;
    waits        = 0;
    forever begin
      if (waits >= 50) begin
        check("send_timeout", 64'(waits), 64'd0);
        core_valid_i = 1'b0;
        return;
      end
      #1;
      acc = core_ready_o;
      @(posedge clk);
      #1;
      waits++;
      if (acc) begin
        sb_q.push_back(d[31:0]);
        sb_q.push_back(d[63:32]);
        return;
      end
    end
  endtask

  initial begin
    int w;
    logic [63:0] d;

    // Reset state
    rst = 1'b1;
    core_valid_i = 1'b0;
    core_data_i = '0;
    token_i = 2'b00;
    ch_ready_i = 2'b11;
    #2;
    check("rst_credit0", 64'(credit0_o), 64'd16);
    check("rst_credit1", 64'(credit1_o), 64'd16);
    check("rst_sent", 64'(sent_cnt_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_ch_valid", 64'(ch_valid_o), 64'd0);
    check("rst_core_ready", 64'(core_ready_o), 64'd1);
    check("rst_data", {ch1_data_o, ch0_data_o}, 64'd0);
    apply_reset();

    // Single word
    send_word(64'h1111_2222_3333_4444, w);
    core_valid_i = 1'b0;
    check("single_accept_wait", 64'(w), 64'd1);
    tick(3);
    check("single_sent", 64'(sent_cnt_o), 64'd2);
    check("single_credit0", 64'(credit0_o), 64'd14);
    check("single_credit1", 64'(credit1_o), 64'd14);
    check("single_idle_ready", 64'(core_ready_o), 64'd1);

    // Back-to-back: every word after the first is accepted exactly 2 cycles later
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      d = 64'hB2B0_0000_0000_0000 | (64'(i) << 32) | (64'(i) + 64'h0000_0000_AA00_0055);
      send_word(d, w);
      check("b2b_accept_cycles", 64'(w), (i == 0) ? 64'd1 : 64'd2);
    end
    core_valid_i = 1'b0;
    tick(3);
    check("b2b_sent", 64'(sent_cnt_o), 64'd8);
    check("b2b_credit0", 64'(credit0_o), 64'd8);
    check("b2b_credit1", 64'(credit1_o), 64'd8);

    // Credit exhaustion: 8 words drain the pool, 9th word waits in BEAT0
    apply_reset();
    for (int i = 0; i < 8; i++) send_word(64'hC0DE_0000_0000_0000 | 64'(i), w);
    d = 64'h9999_8888_7777_6666;
    send_word(d, w);
    core_valid_i = 1'b0;
    check("exh_credit0", 64'(credit0_o), 64'd0);
    check("exh_credit1", 64'(credit1_o), 64'd0);
    check("exh_sent", 64'(sent_cnt_o), 64'd16);
    tick(2);
    check("exh_valid_low", 64'(ch_valid_o), 64'd0);
    check("exh_held_data", {ch1_data_o, ch0_data_o}, 64'h7777_6666);
    token_i = 2'b01;
    tick(1);
    check("exh_tok0_credit0", 64'(credit0_o), 64'd4);
    check("exh_tok0_credit1", 64'(credit1_o), 64'd0);
    check("exh_tok0_valid_low", 64'(ch_valid_o), 64'd0);
    token_i = 2'b11;
    tick(1);
    check("exh_tok1_credit1", 64'(credit1_o), 64'd4);
    check("exh_tok1_valid", 64'(ch_valid_o), 64'd1);
    check("exh_tok1_data", {ch1_data_o, ch0_data_o}, 64'h7777_6666);
    tick(3);
    check("exh_end_sent", 64'(sent_cnt_o), 64'd18);
    check("exh_end_credit0", 64'(credit0_o), 64'd2);

    // Backpressure: ch1 not ready holds the beat
    apply_reset();
    ch_ready_i = 2'b01;
    send_word(64'hDEAD_BEEF_CAFE_F00D, w);
    core_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_valid", 64'(ch_valid_o), 64'd1);
      check("bp_data", {ch1_data_o, ch0_data_o}, 64'hCAFE_F00D);
      check("bp_credit0", 64'(credit0_o), 64'd16);
      check("bp_sent", 64'(sent_cnt_o), 64'd0);
    end
    ch_ready_i = 2'b11;
    tick(1);
    check("bp_release_sent", 64'(sent_cnt_o), 64'd1);
    check("bp_release_beat1", {ch1_data_o, ch0_data_o}, 64'hDEAD_BEEF);
    check("bp_release_credit0", 64'(credit0_o), 64'd15);
    tick(2);
    check("bp_done_sent", 64'(sent_cnt_o), 64'd2);

    // Token edge coinciding with fire, from credit 10
    apply_reset();
    for (int i = 0; i < 3; i++) send_word(64'h5A5A_0000_0000_A5A5 | (64'(i) << 16), w);
    core_valid_i = 1'b0;
    tick(3);
    check("tf_pre_credit0", 64'(credit0_o), 64'd10);
    send_word(64'h0123_4567_89AB_CDEF, w);
    core_valid_i = 1'b0;
    token_i = 2'b01;
    tick(1);
    check("tf_credit0", 64'(credit0_o), 64'd13);
    check("tf_credit1", 64'(credit1_o), 64'd9);
    tick(2);
    check("tf_after_credit0", 64'(credit0_o), 64'd12);
    check("tf_after_credit1", 64'(credit1_o), 64'd8);
    check("tf_no_err", 64'(err_o), 64'd0);

    // Saturation from 14 sets sticky err_o
    apply_reset();
    send_word(64'hFACE_0001_FACE_0002, w);
    core_valid_i = 1'b0;
    tick(3);
    token_i = 2'b01;
    tick(1);
    check("sat_credit0", 64'(credit0_o), 64'd16);
    check("sat_credit1", 64'(credit1_o), 64'd14);
    check("sat_err", 64'(err_o), 64'd1);
    tick(3);
    check("sat_err_sticky", 64'(err_o), 64'd1);

    // Asynchronous reset in BEAT1
    send_word(64'hAAAA_BBBB_CCCC_DDDD, w);
    core_valid_i = 1'b0;
    tick(1);
    check("ar_beat1_valid", 64'(ch_valid_o), 64'd1);
    check("ar_beat1_data", {ch1_data_o, ch0_data_o}, 64'hAAAA_BBBB);
    check("ar_beat1_sent", 64'(sent_cnt_o), 64'd3);
    #2;
    token_i = 2'b00;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("ar_valid", 64'(ch_valid_o), 64'd0);
    check("ar_ready", 64'(core_ready_o), 64'd1);
    check("ar_data", {ch1_data_o, ch0_data_o}, 64'd0);
    check("ar_sent", 64'(sent_cnt_o), 64'd0);
    check("ar_credit0", 64'(credit0_o), 64'd16);
    check("ar_credit1", 64'(credit1_o), 64'd16);
    check("ar_err", 64'(err_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    check("ar_post_valid", 64'(ch_valid_o), 64'd0);
    check("ar_post_sent", 64'(sent_cnt_o), 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
